// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the RV32IM pipeline stage registers.
//   - Payload widths for every inter-stage register (IF/ID, ID/EX, EX/MEM, MEM/WB)
//   - Bit offsets used to pack/unpack the ID/EX data and control payloads
//   - Packed control-bundle structs per stage
//   - Occupancy state encoding used by pipe_stage_reg
//   - id_ex_data_pack(): builds a 133-bit ID/EX data payload from its fields
// -----------------------------------------------------------------------------
package pipe_pkg;

    // Payload widths per stage boundary
    localparam int IF_ID_DATA_W  = 64;   // PC, INSTR
    localparam int IF_ID_CTRL_W  = 1;    // PRED_TAKEN
    localparam int ID_EX_DATA_W  = 133;  // PC, D1, D2, SIGN, ADD
    localparam int ID_EX_CTRL_W  = 17;   // OP1, OP2, ALU, BS, MW, MR, W_REG, REG_EN
    localparam int EX_MEM_DATA_W = 101;  // PC, ALU_RES, D2, ADD
    localparam int EX_MEM_CTRL_W = 8;    // MW, MR, W_REG, REG_EN
    localparam int MEM_WB_DATA_W = 101;  // PC, ALU_RES, MEM_RD, ADD
    localparam int MEM_WB_CTRL_W = 3;    // W_REG, REG_EN

    // ID/EX data payload field offsets (LSB position)
    localparam int ID_EX_ADD_LSB  = 0;   // 5 bits, destination register
    localparam int ID_EX_SIGN_LSB = 5;   // 32 bits, sign-extended immediate
    localparam int ID_EX_D2_LSB   = 37;  // 32 bits, rs2 value
    localparam int ID_EX_D1_LSB   = 69;  // 32 bits, rs1 value
    localparam int ID_EX_PC_LSB   = 101; // 32 bits, program counter

    // ID/EX control payload field offsets (LSB position)
    localparam int ID_EX_REG_EN_LSB = 0;  // 1 bit
    localparam int ID_EX_W_REG_LSB  = 1;  // 2 bits, writeback source select
    localparam int ID_EX_MR_LSB     = 3;  // 3 bits, load type
    localparam int ID_EX_MW_LSB     = 6;  // 2 bits, store size
    localparam int ID_EX_BS_LSB     = 8;  // 3 bits, branch select
    localparam int ID_EX_ALU_LSB    = 11; // 4 bits, ALU op
    localparam int ID_EX_OP2_LSB    = 15; // 1 bit, operand-2 select
    localparam int ID_EX_OP1_LSB    = 16; // 1 bit, operand-1 select

    typedef struct packed {
        logic       pred_taken;
    } if_id_ctrl_t;

    typedef struct packed {
        logic       op1;
        logic       op2;
        logic [3:0] alu;
        logic [2:0] bs;
        logic [1:0] mw;
        logic [2:0] mr;
        logic [1:0] w_reg;
        logic       reg_en;
    } id_ex_ctrl_t;

    typedef struct packed {
        logic [1:0] mw;
        logic [2:0] mr;
        logic [1:0] w_reg;
        logic       reg_en;
    } ex_mem_ctrl_t;

    typedef struct packed {
        logic [1:0] w_reg;
        logic       reg_en;
    } mem_wb_ctrl_t;

    // Occupancy of a stage register; 2'b10 is unused and recovers to EMPTY
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_FULL  = 2'b11
    } stage_state_e;

    function automatic logic [ID_EX_DATA_W-1:0] id_ex_data_pack(
        input logic [31:0] pc,
        input logic [31:0] d1,
        input logic [31:0] d2,
        input logic [31:0] sign,
        input logic [4:0]  add
    );
        logic [ID_EX_DATA_W-1:0] v;
        v = {ID_EX_DATA_W{1'b0}};
        v[ID_EX_PC_LSB   +: 32] = pc;
        v[ID_EX_D1_LSB   +: 32] = d1;
        v[ID_EX_D2_LSB   +: 32] = d2;
        v[ID_EX_SIGN_LSB +: 32] = sign;
        v[ID_EX_ADD_LSB  +: 5]  = add;
        return v;
    endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// -----------------------------------------------------------------------------
// pipe_stage_reg
// Generic pipeline stage register with valid/ready flow control, flush and an
// optional skid slot. Payloads are opaque; packing happens at the instance.
//
// Build option: define PIPE_STAGE_SKID_EN to add the skid slot S. With it,
// IN_READY depends only on registered state (no path from OUT_READY). Without
// it, IN_READY = RESET_N & (!M_V | OUT_READY) and the stage holds one entry.
//
// Ports:
//   CLK        clock, all state on rising edge
//   RESET_N    synchronous active-low reset (overrides FLUSH and handshakes)
//   FLUSH      drop every held entry at the next edge
//   IN_VALID / IN_READY / IN_DATA / IN_CTRL      upstream handshake + payload
//   OUT_VALID / OUT_READY / OUT_DATA / OUT_CTRL  downstream handshake + payload
//                                                (OUT_CTRL is zero on bubbles)
//   OCC        number of held entries
// -----------------------------------------------------------------------------
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int DATA_W = ID_EX_DATA_W,
    parameter int CTRL_W = ID_EX_CTRL_W
) (
    input  logic              CLK,
    input  logic              RESET_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [DATA_W-1:0] IN_DATA,
    input  logic [CTRL_W-1:0] IN_CTRL,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [DATA_W-1:0] OUT_DATA,
    output logic [CTRL_W-1:0] OUT_CTRL,
    output logic [1:0]        OCC
);

    stage_state_e      state_q, state_d;
    logic [DATA_W-1:0] m_data_q, m_data_d;
    logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
    logic [DATA_W-1:0] s_data_q, s_data_d;
    logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
    logic              s_v_s;
`endif
    logic              m_v_s;
    logic              accept_s;
    logic              release_s;

    assign m_v_s = (state_q != ST_EMPTY);
`ifdef PIPE_STAGE_SKID_EN
    assign s_v_s = (state_q == ST_FULL);
    // Ready comes from the skid flag only, breaking the ready chain
    assign IN_READY = RESET_N & ~s_v_s;
    assign OCC      = {1'b0, m_v_s} + {1'b0, s_v_s};
`else
    assign IN_READY = RESET_N & (~m_v_s | OUT_READY);
    assign OCC      = {1'b0, m_v_s};
`endif

    assign accept_s  = IN_VALID & IN_READY;
    assign release_s = m_v_s & OUT_READY;

    assign OUT_VALID = m_v_s;
    assign OUT_DATA  = m_data_q;
    // m_ctrl_q is kept at zero whenever M is empty, so bubbles are inert
    assign OUT_CTRL  = m_ctrl_q;

    // Next-state and slot update logic
    always_comb begin
        state_d  = state_q;
        m_data_d = m_data_q;
        m_ctrl_d = m_ctrl_q;
`ifdef PIPE_STAGE_SKID_EN
        s_data_d = s_data_q;
        s_ctrl_d = s_ctrl_q;
`endif
        case (state_q)
            ST_EMPTY: begin
                if (accept_s) begin
                    state_d  = ST_ONE;
                    m_data_d = IN_DATA;
                    m_ctrl_d = IN_CTRL;
                end else begin
                    state_d  = ST_EMPTY;
                end
            end
            ST_ONE: begin
                if (accept_s && release_s) begin
                    state_d  = ST_ONE;
                    m_data_d = IN_DATA;
                    m_ctrl_d = IN_CTRL;
`ifdef PIPE_STAGE_SKID_EN
                end else if (accept_s) begin
                    state_d  = ST_FULL;
                    s_data_d = IN_DATA;
                    s_ctrl_d = IN_CTRL;
`endif
                end else if (release_s) begin
                    state_d  = ST_EMPTY;
                end else begin
                    state_d  = ST_ONE;
                end
            end
`ifdef PIPE_STAGE_SKID_EN
            ST_FULL: begin
                // IN_READY is low here, so only a release can happen
                if (release_s) begin
                    state_d  = ST_ONE;
                    m_data_d = s_data_q;
                    m_ctrl_d = s_ctrl_q;
                end else begin
                    state_d  = ST_FULL;
                end
            end
`endif
            default: begin
                state_d = ST_EMPTY;
            end
        endcase

        // Flush wins over the handshakes; data keeps its last held value
        if (FLUSH) begin
            state_d  = ST_EMPTY;
            m_data_d = m_data_q;
`ifdef PIPE_STAGE_SKID_EN
            s_data_d = s_data_q;
`endif
        end else begin
            state_d  = state_d;
        end

        // Empty slots never carry live control bits
        if (state_d == ST_EMPTY) begin
            m_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            m_ctrl_d = m_ctrl_d;
        end
`ifdef PIPE_STAGE_SKID_EN
        if (state_d != ST_FULL) begin
            s_ctrl_d = {CTRL_W{1'b0}};
        end else begin
            s_ctrl_d = s_ctrl_d;
        end
`endif
    end

    // State and slot registers with synchronous active-low reset
    always_ff @(posedge CLK) begin
        if (!RESET_N) begin
            state_q  <= ST_EMPTY;
            m_data_q <= {DATA_W{1'b0}};
            m_ctrl_q <= {CTRL_W{1'b0}};
`ifdef PIPE_STAGE_SKID_EN
            s_data_q <= {DATA_W{1'b0}};
            s_ctrl_q <= {CTRL_W{1'b0}};
`endif
        end else begin
            state_q  <= state_d;
            m_data_q <= m_data_d;
            m_ctrl_q <= m_ctrl_d;
`ifdef PIPE_STAGE_SKID_EN
            s_data_q <= s_data_d;
            s_ctrl_q <= s_ctrl_d;
`endif
        end
    end

endmodule
